flash_dump_ctrl: RTL and testbench
==================================

Name: flash_dump_ctrl

Overview:
- Parametrised successor to the single-byte flash-read test sequencer.
- On a start pulse, reads a run of iLength consecutive bytes from the SPI flash read engine (SpiFlash rd/done handshake), beginning at iStartAddr.
- Streams each byte into the UART TX FIFO, honouring the FIFO full flag.
- Supports abort, address wrap-around and status reporting; an optional ASCII-hex formatter makes dumps human-readable on a terminal.

Parameters:
- ADDR_W, 24, flash byte-address width; oRdAddr is zero-extended to 32 bits at the SpiFlash boundary by the integrator.
- LEN_W, 16, width of the byte-count request. Maximum run is 2^LEN_W-1 bytes.
- BYTES_PER_LINE, 16, bytes per output line. Used only when FLASH_DUMP_HEX_EN is defined; must be at least 1.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle start pulse. Sampled only in S_IDLE.
- iStartAddr  in  ADDR_W  first byte address. Latched on an accepted iStart.
- iLength  in  LEN_W  number of bytes to read. Latched on an accepted iStart.
- iAbort  in  1  level/pulse abort request.
- oRdReq  out  1  one-cycle read request to the flash engine.
- oRdAddr  out  ADDR_W  read address. Stable from oRdReq until iRdDone.
- iRdDone  in  1  flash read complete (one-cycle pulse).
- iRdData  in  8  flash byte. Valid when iRdDone=1.
- oTxStart  out  1  one-cycle write strobe into the UART TX FIFO.
- oTxData  out  8  character for the FIFO. Valid with oTxStart.
- iTxFull  in  1  UART TX FIFO full.
- oBusy  out  1  high in every state except S_IDLE.
- oDone  out  1  one-cycle pulse when a run ends, whether normally or by abort.
- oAborted  out  1  registered flag: set with an abort-terminated oDone, cleared on the next accepted iStart.
- oByteCount  out  LEN_W  number of bytes fully transmitted in the current or last run.

Behaviour:
- Reset: all outputs are 0, oRdAddr=0, state S_IDLE. The reset action is the same in every state, including with a read outstanding. Any late iRdDone after reset is ignored in S_IDLE.
- All outputs are registered.
- States: S_IDLE, S_REQ, S_WAIT_RD, S_TX, S_DONE.
- S_IDLE, on iStart:
  - Latch address and length; clear oByteCount and oAborted.
  - If iLength=0, go to S_DONE: oDone pulses 2 cycles after iStart and no reads are issued.
  - Otherwise go to S_REQ.
- S_REQ: assert oRdReq for exactly one cycle with oRdAddr set to the current address, then go to S_WAIT_RD. First oRdReq appears 2 cycles after iStart.
- S_WAIT_RD: on iRdDone, latch iRdData and go to S_TX.
- S_TX: emit the character(s) for the byte.
  - A character is issued only in a cycle where iTxFull=0; oTxStart pulses for one cycle per character.
  - While iTxFull=1, hold the state and keep oTxStart=0.
  - After the last character of the byte: increment oByteCount and the address, decrement the remaining count.
  - If the remaining count reaches 0, go to S_DONE; otherwise go to S_REQ.
- Address arithmetic is modulo 2^ADDR_W: address all-ones wraps to 0 without error.
- S_DONE: pulse oDone for one cycle, then return to S_IDLE.
- iStart while oBusy=1 is ignored; no queuing.
- Abort:
  - iAbort in S_REQ or S_TX: go to S_DONE on the next cycle and set oAborted. oTxStart is not asserted in that cycle.
  - iAbort in S_WAIT_RD: record the abort and stay until iRdDone, because the flash transaction cannot be cancelled. Discard the data, then go to S_DONE.
  - iAbort in S_IDLE or S_DONE: no effect.
  - iAbort in the same cycle as the final byte's last oTxStart: the run completes normally; the byte is counted and oAborted=0.
- Throughput: at most one byte per (flash latency + 3) cycles; no pipelined read-ahead.

Optional Feature:
- Macro FLASH_DUMP_HEX_EN.
- Defined:
  - Each byte is emitted as two uppercase ASCII hex characters, high nibble first, e.g. 8'h3A gives 8'h33 then 8'h41.
  - After every BYTES_PER_LINE bytes, and after the final byte of the run, emit 8'h0D then 8'h0A.
  - Each character independently waits for iTxFull=0.
  - oByteCount increments only after all characters for the byte, including any CR/LF, have been issued.
  - Abort mid-byte drops the remaining characters of that byte.
- Undefined: the raw byte is emitted as exactly one character, and BYTES_PER_LINE is unused.

Decomposition:
- Package flash_dump_pkg:
  - FLASH_DUMP_STATE enum.
  - ASCII constants CHAR_CR=8'h0D and CHAR_LF=8'h0A.
  - A nibble-to-ASCII function.
- One sub-module: flash_dump_fmt, the per-byte character sequencer (nibble index, line counter, CR/LF). It is instantiated only under FLASH_DUMP_HEX_EN.

Test Plan:
- Raw mode: iStartAddr=0x000010, iLength=1, flash returns 0xA5, iTxFull=0. Required: one oRdReq with addr 0x10; oTxData=0xA5; oDone; oByteCount=1; oAborted=0.
- Raw mode: iLength=4 from 0x000100, bytes 11/22/33/44, iTxFull held high 5 cycles before each byte. Required: oTxStart only when iTxFull=0; data order 11,22,33,44; addresses 0x100..0x103.
- iLength=0. Required: no oRdReq; oDone exactly 2 cycles after iStart; oByteCount=0.
- iStartAddr=0xFFFFFE, iLength=3. Required: read addresses FFFFFE, FFFFFF, 000000.
- Abort asserted during S_WAIT_RD of the 2nd byte of a 4-byte run. Required: iRdDone still awaited; that byte is not sent; oDone with oAborted=1 and oByteCount=1. A following iStart clears oAborted.
- FLASH_DUMP_HEX_EN defined, BYTES_PER_LINE=2, bytes 3A, 0F, C7. Required character stream: "3" "A" "0" "F" CR LF "C" "7" CR LF; oByteCount=3.

Source files
------------

// File: rtl/flash_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_dump_pkg
// Purpose  : Shared types, character constants and helpers for the flash dump
//            controller and its ASCII-hex character sequencer.
// Contents : flash_dump_state_t  - controller state encoding
//            CHAR_CR / CHAR_LF   - line terminator characters
//            nibble_to_ascii()   - 4-bit value to uppercase ASCII hex digit
// Revision : 1.0 - initial release
// ============================================================================
package flash_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT_RD = 3'd2,
    S_TX      = 3'd3,
    S_DONE    = 3'd4
  } flash_dump_state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // 0-9 map onto '0'..'9' (0x30..0x39), 10-15 onto 'A'..'F' (0x41..0x46).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_dump_fmt.sv
`default_nettype none
// ============================================================================
// Module   : flash_dump_fmt
// Purpose  : Per-byte character sequencer for the ASCII-hex dump format.
//            Presents the current character for the byte being emitted:
//            high nibble, low nibble, then CR and LF at end of line or run.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clear         - start of a new run (resets nibble/line position)
//            advance       - the presented character was issued
//            last_byte     - the byte being emitted is the final one of the run
//            data          - byte being emitted
//            char_out      - character to issue now
//            last_char     - char_out is the final character for this byte
// Revision : 1.0 - initial release
// ============================================================================
module flash_dump_fmt
  import flash_dump_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  input  logic       last_byte,
  input  logic [7:0] data,
  output logic [7:0] char_out,
  output logic       last_char
);

  localparam int                LINE_W    = $clog2(BYTES_PER_LINE + 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(BYTES_PER_LINE - 1);

  // Phase within the byte: 0 high nibble, 1 low nibble, 2 CR, 3 LF.
  logic [1:0]        r_phase;
  logic [LINE_W-1:0] r_line_cnt;
  logic              w_eol;

  // Line ends after this byte when the line is full or the run is finishing.
  assign w_eol = last_byte || (r_line_cnt == LINE_LAST);

  always_comb begin
    char_out  = nibble_to_ascii(data[7:4]);
    last_char = 1'b0;
    case (r_phase)
      2'd0: char_out = nibble_to_ascii(data[7:4]);
      2'd1: begin
        char_out  = nibble_to_ascii(data[3:0]);
        last_char = !w_eol;
      end
      2'd2: char_out = CHAR_CR;
      default: begin
        char_out  = CHAR_LF;
        last_char = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_phase    <= 2'd0;
      r_line_cnt <= '0;
    end else if (advance) begin
      if (last_char) begin
        r_phase    <= 2'd0;
        r_line_cnt <= w_eol ? '0 : r_line_cnt + LINE_W'(1);
      end else begin
        r_phase <= r_phase + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flash_dump_ctrl
// Purpose  : Reads a run of consecutive bytes from the SPI flash read engine
//            and streams them into the UART TX FIFO, with abort, address
//            wrap-around and run status. Build option FLASH_DUMP_HEX_EN turns
//            each byte into two ASCII hex characters plus CR/LF line breaks.
// Ports    : iClk, iRst               - clock, synchronous active-high reset
//            iStart/iStartAddr/iLength - run request (sampled only when idle)
//            iAbort                   - abort request
//            oRdReq/oRdAddr           - flash read request and address
//            iRdDone/iRdData          - flash read completion and data
//            oTxStart/oTxData/iTxFull - UART TX FIFO write interface
//            oBusy/oDone/oAborted     - run status
//            oByteCount               - bytes fully transmitted this run
// Macro    : FLASH_DUMP_HEX_EN - enable ASCII-hex formatting
// Revision : 1.0 - initial release
// ============================================================================
module flash_dump_ctrl
  import flash_dump_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int LEN_W          = 16,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iStartAddr,
  input  logic [LEN_W-1:0]  iLength,
  input  logic              iAbort,
  output logic              oRdReq,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic              iRdDone,
  input  logic [7:0]        iRdData,
  output logic              oTxStart,
  output logic [7:0]        oTxData,
  input  logic              iTxFull,
  output logic              oBusy,
  output logic              oDone,
  output logic              oAborted,
  output logic [LEN_W-1:0]  oByteCount
);

  if (BYTES_PER_LINE < 1) begin : g_bpl_check
    $error("flash_dump_ctrl: BYTES_PER_LINE must be at least 1");
  end

  flash_dump_state_t r_state, w_state_nxt;

  logic [LEN_W-1:0]  r_remain;
  logic [7:0]        r_byte;
  logic              r_abort_pend;

  logic [LEN_W-1:0]  w_remain_nxt;
  logic [7:0]        w_byte_nxt;
  logic              w_abort_pend_nxt;
  logic              w_rd_req_nxt;
  logic              w_tx_start_nxt;
  logic [7:0]        w_tx_data_nxt;
  logic              w_done_nxt;
  logic              w_aborted_nxt;
  logic [LEN_W-1:0]  w_count_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  logic [7:0]        w_char;
  logic              w_last_char;
  logic              w_last_byte;
  logic              w_tx_abort;

  assign w_last_byte = (r_remain == LEN_W'(1));

  // An abort that coincides with issuing the very last character of the run
  // loses: the run completes normally and the byte is counted.
  assign w_tx_abort = iAbort && !(!iTxFull && w_last_char && w_last_byte);

`ifdef FLASH_DUMP_HEX_EN
  logic w_fmt_clear;
  logic w_fmt_adv;

  assign w_fmt_clear = (r_state == S_IDLE) && iStart;
  assign w_fmt_adv   = (r_state == S_TX) && !iTxFull && !w_tx_abort;

  flash_dump_fmt #(
    .BYTES_PER_LINE (BYTES_PER_LINE)
  ) u_fmt (
    .clk       (iClk),
    .rst       (iRst),
    .clear     (w_fmt_clear),
    .advance   (w_fmt_adv),
    .last_byte (w_last_byte),
    .data      (r_byte),
    .char_out  (w_char),
    .last_char (w_last_char)
  );
`else
  assign w_char      = r_byte;
  assign w_last_char = 1'b1;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_remain_nxt     = r_remain;
    w_byte_nxt       = r_byte;
    w_abort_pend_nxt = r_abort_pend;
    w_rd_req_nxt     = 1'b0;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = oTxData;
    w_done_nxt       = 1'b0;
    w_aborted_nxt    = oAborted;
    w_count_nxt      = oByteCount;
    w_addr_nxt       = oRdAddr;

    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_addr_nxt       = iStartAddr;
          w_remain_nxt     = iLength;
          w_count_nxt      = '0;
          w_aborted_nxt    = 1'b0;
          w_abort_pend_nxt = 1'b0;
          w_state_nxt      = (iLength == '0) ? S_DONE : S_REQ;
        end
      end

      S_REQ: begin
        if (iAbort) begin
          w_abort_pend_nxt = 1'b1;
          w_state_nxt      = S_DONE;
        end else begin
          w_rd_req_nxt = 1'b1;
          w_state_nxt  = S_WAIT_RD;
        end
      end

      // The flash transaction cannot be cancelled: an abort is remembered and
      // acted on once the read completes, and the returned byte is dropped.
      S_WAIT_RD: begin
        if (iAbort) begin
          w_abort_pend_nxt = 1'b1;
        end
        if (iRdDone) begin
          if (iAbort || r_abort_pend) begin
            w_state_nxt = S_DONE;
          end else begin
            w_byte_nxt  = iRdData;
            w_state_nxt = S_TX;
          end
        end
      end

      S_TX: begin
        if (w_tx_abort) begin
          w_abort_pend_nxt = 1'b1;
          w_state_nxt      = S_DONE;
        end else if (!iTxFull) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = w_char;
          if (w_last_char) begin
            w_count_nxt  = oByteCount + LEN_W'(1);
            w_addr_nxt   = oRdAddr + ADDR_W'(1);
            w_remain_nxt = r_remain - LEN_W'(1);
            w_state_nxt  = w_last_byte ? S_DONE : S_REQ;
          end
        end
      end

      S_DONE: begin
        w_done_nxt    = 1'b1;
        w_aborted_nxt = r_abort_pend;
        w_state_nxt   = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= S_IDLE;
      r_remain     <= '0;
      r_byte       <= '0;
      r_abort_pend <= 1'b0;
      oRdReq       <= 1'b0;
      oRdAddr      <= '0;
      oTxStart     <= 1'b0;
      oTxData      <= '0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oAborted     <= 1'b0;
      oByteCount   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_remain     <= w_remain_nxt;
      r_byte       <= w_byte_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      oRdReq       <= w_rd_req_nxt;
      oRdAddr      <= w_addr_nxt;
      oTxStart     <= w_tx_start_nxt;
      oTxData      <= w_tx_data_nxt;
      oBusy        <= (w_state_nxt != S_IDLE);
      oDone        <= w_done_nxt;
      oAborted     <= w_aborted_nxt;
      oByteCount   <= w_count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_dump_ctrl
// Purpose  : Self-checking bench for flash_dump_ctrl. A flash responder with
//            fixed latency answers reads from a sparse byte map; a run-level
//            model predicts read addresses, the character stream and the
//            final status of each run, checked every cycle by tick().
// Macro    : FLASH_DUMP_HEX_EN - must match the build of the design
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_dump_ctrl;

  localparam int ADDR_W = 24;
  localparam int LEN_W  = 16;
  localparam int BPL    = 2;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              iStart;
  logic [ADDR_W-1:0] iStartAddr;
  logic [LEN_W-1:0]  iLength;
  logic              iAbort;
  logic              oRdReq;
  logic [ADDR_W-1:0] oRdAddr;
  logic              iRdDone;
  logic [7:0]        iRdData;
  logic              oTxStart;
  logic [7:0]        oTxData;
  logic              iTxFull;
  logic              oBusy;
  logic              oDone;
  logic              oAborted;
  logic [LEN_W-1:0]  oByteCount;

  always #5 clk = ~clk;

  flash_dump_ctrl #(
    .ADDR_W         (ADDR_W),
    .LEN_W          (LEN_W),
    .BYTES_PER_LINE (BPL)
  ) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iStart     (iStart),
    .iStartAddr (iStartAddr),
    .iLength    (iLength),
    .iAbort     (iAbort),
    .oRdReq     (oRdReq),
    .oRdAddr    (oRdAddr),
    .iRdDone    (iRdDone),
    .iRdData    (iRdData),
    .oTxStart   (oTxStart),
    .oTxData    (oTxData),
    .iTxFull    (iTxFull),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oAborted   (oAborted),
    .oByteCount (oByteCount)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rdreq = 0;
  int n_done = 0;
  int n_rddone = 0;
  int done_cyc = 0;
  int done_rd = 0;
  int first_req_cyc = -1;
  bit stall_en = 1'b0;
  logic full_at_edge = 1'b0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [7:0]        exp_char[$];
  logic [ADDR_W-1:0] obs_addr[$];
  logic [7:0]        obs_char[$];
  int                exp_count = 0;
  bit                exp_aborted = 1'b0;

  logic [7:0] mem [int];

  function automatic logic [7:0] fbyte(input logic [ADDR_W-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] hexch(input logic [3:0] n);
    string d = "0123456789ABCDEF";
    return d[int'(n)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // FIFO full level seen by the DUT at each edge; a write strobe visible now
  // was decided at that edge.
  always @(posedge clk) full_at_edge <= iTxFull;

  // Flash read engine: fixed latency, optional 5-cycle FIFO-full burst
  // starting with each returned byte.
  initial begin
    logic [ADDR_W-1:0] a;
    iRdDone = 1'b0;
    iRdData = 8'h00;
    iTxFull = 1'b0;
    forever begin
      @(negedge clk);
      iRdDone = 1'b0;
      if (oRdReq && !rst) begin
        a = oRdAddr;
        repeat (RD_LAT) @(negedge clk);
        iRdDone = 1'b1;
        iRdData = fbyte(a);
        n_rddone++;
        if (stall_en) begin
          iTxFull = 1'b1;
          @(negedge clk);
          iRdDone = 1'b0;
          repeat (4) @(negedge clk);
          iTxFull = 1'b0;
        end
      end
    end
  end

  // One cycle: advance to the next sampling point and check every output
  // event against the model queues.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (oRdReq) begin
      n_rdreq++;
      obs_addr.push_back(oRdAddr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (exp_addr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_addr: got unexpected read of %0h, expected no read", oRdAddr);
      end else begin
        chk("rd_addr", oRdAddr, exp_addr.pop_front());
      end
    end
    if (oTxStart) begin
      obs_char.push_back(oTxData);
      chk("tx_while_full", full_at_edge, 0);
      if (exp_char.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tx_data: got unexpected char %0h, expected no char", oTxData);
      end else begin
        chk("tx_data", oTxData, exp_char.pop_front());
      end
    end
    if (oDone) begin
      n_done++;
      done_cyc = cyc;
      done_rd  = n_rddone;
      chk("done_count", oByteCount, exp_count);
      chk("done_aborted", oAborted, exp_aborted);
      chk("done_busy", oBusy, 0);
      chk("done_rd_left", exp_addr.size(), 0);
      chk("done_tx_left", exp_char.size(), 0);
    end
  endtask

  // Run one dump and check it. abort_rd=k aborts while waiting on read k;
  // abort_tx aborts while the first byte is blocked by a full FIFO.
  task automatic run(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                     input int abort_rd, input bit abort_tx, input bit stall,
                     input bit busy_start, output int start_cyc);
    int nreq, nsent, rq0, dn0, rd0;
    bit armed, fired, got;
    logic [7:0] b;
    chk("aborted_hold", oAborted, exp_aborted);

    exp_addr.delete();
    exp_char.delete();
    nreq  = (abort_rd > 0) ? abort_rd : (abort_tx ? 1 : int'(len));
    nsent = (abort_rd > 0) ? abort_rd - 1 : (abort_tx ? 0 : int'(len));
    for (int i = 0; i < nreq; i++) exp_addr.push_back(addr + ADDR_W'(i));
    for (int i = 0; i < nsent; i++) begin
      b = fbyte(addr + ADDR_W'(i));
`ifdef FLASH_DUMP_HEX_EN
      exp_char.push_back(hexch(b[7:4]));
      exp_char.push_back(hexch(b[3:0]));
      if (((i + 1) % BPL) == 0 || i == int'(len) - 1) begin
        exp_char.push_back(8'h0D);
        exp_char.push_back(8'h0A);
      end
`else
      exp_char.push_back(b);
`endif
    end
    exp_count   = nsent;
    exp_aborted = (abort_rd > 0) || abort_tx;

    stall_en = stall;
    obs_addr.delete();
    obs_char.delete();
    first_req_cyc = -1;
    rq0 = n_rdreq;
    dn0 = n_done;
    rd0 = n_rddone;

    iStartAddr = addr;
    iLength    = len;
    iStart     = 1'b1;
    start_cyc  = cyc;
    tick();
    iStart = 1'b0;
    chk("start_busy", oBusy, 1);
    chk("start_count_clr", oByteCount, 0);
    chk("start_aborted_clr", oAborted, 0);

    got   = 1'b0;
    armed = 1'b0;
    fired = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      tick();
      iAbort = 1'b0;
      iStart = 1'b0;
      if (n_done != dn0) got = 1'b1;
      if (!got && abort_rd > 0 && !fired && (n_rdreq - rq0) == abort_rd) begin
        iAbort = 1'b1;
        fired  = 1'b1;
      end
      if (!got && abort_tx && !fired) begin
        if (armed) begin
          iAbort = 1'b1;
          fired  = 1'b1;
        end else if (n_rddone - rd0 >= 1) begin
          armed = 1'b1;
        end
      end
      if (!got && busy_start && c == 6) begin
        iStart     = 1'b1;
        iStartAddr = 24'h777777;
        iLength    = 16'd9;
      end
    end
    iAbort = 1'b0;
    iStart = 1'b0;
    chk("done_seen_in_budget", got, 1);
    repeat (3) tick();
    chk("single_done", n_done - dn0, 1);
    if (abort_rd > 0) chk("abort_waits_rd", done_rd - rd0, abort_rd);
  endtask

  initial begin
    int s;
    rst        = 1'b1;
    iStart     = 1'b0;
    iStartAddr = '0;
    iLength    = '0;
    iAbort     = 1'b0;
    repeat (3) tick();
    chk("rst_rdreq", oRdReq, 0);
    chk("rst_rdaddr", oRdAddr, 0);
    chk("rst_txstart", oTxStart, 0);
    chk("rst_txdata", oTxData, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_aborted", oAborted, 0);
    chk("rst_count", oByteCount, 0);
    rst = 1'b0;
    tick();

    // Single byte.
    mem[32'h10] = 8'hA5;
    run(24'h000010, 16'd1, 0, 1'b0, 1'b0, 1'b0, s);
    chk("t1_req_latency", first_req_cyc - s, 2);
    chk("t1_nreads", obs_addr.size(), 1);
    if (obs_addr.size() > 0) chk("t1_addr", obs_addr[0], 24'h000010);
`ifndef FLASH_DUMP_HEX_EN
    chk("t1_nchars", obs_char.size(), 1);
    if (obs_char.size() > 0) chk("t1_char", obs_char[0], 8'hA5);
`endif
    chk("t1_count", oByteCount, 1);
    chk("t1_aborted", oAborted, 0);

    // Four bytes with a full FIFO before each, plus a start while busy.
    mem[32'h100] = 8'h11;
    mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33;
    mem[32'h103] = 8'h44;
    run(24'h000100, 16'd4, 0, 1'b0, 1'b1, 1'b1, s);
    chk("t2_nreads", obs_addr.size(), 4);
    if (obs_addr.size() == 4) chk("t2_addr3", obs_addr[3], 24'h000103);
`ifndef FLASH_DUMP_HEX_EN
    chk("t2_nchars", obs_char.size(), 4);
    if (obs_char.size() == 4) begin
      chk("t2_char0", obs_char[0], 8'h11);
      chk("t2_char3", obs_char[3], 8'h44);
    end
`endif
    chk("t2_count", oByteCount, 4);

    // Zero length.
    run(24'h000055, 16'd0, 0, 1'b0, 1'b0, 1'b0, s);
    chk("t3_done_latency", done_cyc - s, 2);
    chk("t3_nreads", obs_addr.size(), 0);
    chk("t3_count", oByteCount, 0);

    // Address wrap.
    run(24'hFFFFFE, 16'd3, 0, 1'b0, 1'b0, 1'b0, s);
    chk("t4_nreads", obs_addr.size(), 3);
    if (obs_addr.size() == 3) begin
      chk("t4_addr0", obs_addr[0], 24'hFFFFFE);
      chk("t4_addr1", obs_addr[1], 24'hFFFFFF);
      chk("t4_addr2", obs_addr[2], 24'h000000);
    end

    // Abort while waiting on the second read.
    run(24'h000300, 16'd4, 2, 1'b0, 1'b0, 1'b0, s);
    chk("t5_aborted", oAborted, 1);
    chk("t5_count", oByteCount, 1);

    // Next start clears the abort flag.
    run(24'h000400, 16'd1, 0, 1'b0, 1'b0, 1'b0, s);
    chk("t6_aborted", oAborted, 0);

    // Abort while the first byte is blocked by a full FIFO.
    run(24'h000500, 16'd3, 0, 1'b1, 1'b1, 1'b0, s);
    chk("t7_nchars", obs_char.size(), 0);
    chk("t7_aborted", oAborted, 1);

    // Reset with a read outstanding; the late completion must be ignored.
    exp_addr.delete();
    exp_char.delete();
    exp_addr.push_back(24'h000700);
    stall_en   = 1'b0;
    iStartAddr = 24'h000700;
    iLength    = 16'd2;
    iStart     = 1'b1;
    tick();
    iStart = 1'b0;
    s = n_rdreq;
    for (int c = 0; c < 20 && n_rdreq == s; c++) tick();
    chk("t8_read_issued", n_rdreq - s, 1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_addr.delete();
    exp_char.delete();
    exp_aborted = 1'b0;
    exp_count   = 0;
    tick();
    chk("t8_rst_rdaddr", oRdAddr, 0);
    chk("t8_rst_busy", oBusy, 0);
    chk("t8_rst_txdata", oTxData, 0);
    chk("t8_rst_aborted", oAborted, 0);
    repeat (10) tick();
    chk("t8_idle_busy", oBusy, 0);
    chk("t8_idle_count", oByteCount, 0);

    // Formatter stream (raw bytes in the default build).
    mem[32'h600] = 8'h3A;
    mem[32'h601] = 8'h0F;
    mem[32'h602] = 8'hC7;
    run(24'h000600, 16'd3, 0, 1'b0, 1'b0, 1'b0, s);
    chk("t9_count", oByteCount, 3);
    begin
`ifdef FLASH_DUMP_HEX_EN
      logic [7:0] want[10] = '{8'h33, 8'h41, 8'h30, 8'h46, 8'h0D, 8'h0A,
                               8'h43, 8'h37, 8'h0D, 8'h0A};
`else
      logic [7:0] want[3] = '{8'h3A, 8'h0F, 8'hC7};
`endif
      chk("t9_nchars", obs_char.size(), $size(want));
      if (obs_char.size() == $size(want)) begin
        foreach (want[i]) chk("t9_char", obs_char[i], want[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal;
  end

endmodule
`default_nettype wire
